// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : Shared VGA timing constants (800x600 @ 60 Hz, 40 MHz pixel
//               clock) and a helper that sums the four segments of a line or
//               frame. Renderers and frame_clock users import this package so
//               they all see one definition of the timing.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    // Counter width and the largest total the counters can represent
    localparam int c_CNT_W     = 11;
    localparam int c_CNT_LIMIT = 2048;

    // Horizontal timing, in pixel clocks
    localparam int c_H_ACTIVE  = 800;
    localparam int c_H_FP      = 40;
    localparam int c_H_SYNC    = 128;
    localparam int c_H_BP      = 88;

    // Vertical timing, in lines
    localparam int c_V_ACTIVE  = 600;
    localparam int c_V_FP      = 1;
    localparam int c_V_SYNC    = 4;
    localparam int c_V_BP      = 23;

    // 1 = sync pulses are active-high
    localparam int c_SYNC_POL  = 1;

    // Total length of one line or one frame from its four segments
    function automatic int timing_total(input int active, input int fp,
                                        input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int c_H_TOTAL   = c_H_ACTIVE + c_H_FP + c_H_SYNC + c_H_BP;  // 1056
    localparam int c_V_TOTAL   = c_V_ACTIVE + c_V_FP + c_V_SYNC + c_V_BP;  // 628

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_wrap_counter.sv
`default_nettype none
// ============================================================================
// Module      : wrap_counter
// Description : Generic up-counter that wraps from MAX back to 0. Besides the
//               registered count it exposes the value it will load on the
//               next clock, so a parent can decode registered strobes that
//               line up with the count in the same cycle.
// Ports       : clk      - clock
//               rst_n    - asynchronous active-low reset (count -> 0)
//               i_en     - count enable
//               o_count  - current (registered) count
//               o_next   - value loaded on the next clock edge
//               o_tc     - terminal count: o_count == MAX
// Revision    : 1.0 - initial release
// ============================================================================
module wrap_counter #(
    parameter int WIDTH = 11,
    parameter int MAX   = 1055
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count,
    output logic [WIDTH-1:0] o_next,
    output logic             o_tc
);

    localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MAX);

    logic [WIDTH-1:0] r_count;

    always_comb begin
        o_tc   = (r_count == c_MAX);
        o_next = r_count;
        if (i_en) begin
            o_next = o_tc ? '0 : r_count + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= o_next;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : VGA raster timing generator. Two wrapping counters walk the
//               pixel column and line; sync, blanking, display-enable and
//               end-of-frame strobes are decoded from the counters' next
//               values and registered, so every output is a flop and is
//               aligned with the hcount/vcount shown in the same cycle.
// Ports       : pclk      - pixel clock
//               rst_n     - asynchronous active-low reset
//               hcount    - current pixel column (11 bit)
//               vcount    - current line (11 bit)
//               hsync     - horizontal sync, polarity set by SYNC_POL
//               vsync     - vertical sync, polarity set by SYNC_POL
//               hblnk     - horizontal blanking (hcount >= H_ACTIVE)
//               vblnk     - vertical blanking (vcount >= V_ACTIVE)
//               de        - display enable (visible pixel)
//               frame_end - one-cycle pulse on the last pixel of a frame
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = c_H_ACTIVE,
    parameter int H_FP     = c_H_FP,
    parameter int H_SYNC   = c_H_SYNC,
    parameter int H_BP     = c_H_BP,
    parameter int V_ACTIVE = c_V_ACTIVE,
    parameter int V_FP     = c_V_FP,
    parameter int V_SYNC   = c_V_SYNC,
    parameter int V_BP     = c_V_BP,
    parameter int SYNC_POL = c_SYNC_POL
) (
    input  logic               pclk,
    input  logic               rst_n,
    output logic [c_CNT_W-1:0] hcount,
    output logic [c_CNT_W-1:0] vcount,
    output logic               hsync,
    output logic               vsync,
    output logic               hblnk,
    output logic               vblnk,
    output logic               de,
    output logic               frame_end
);

    localparam int c_HTOT = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int c_VTOT = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    // Decode compares are done one bit wider than the counters so a boundary
    // equal to 2048 (legal for a sync end) does not alias to 0.
    localparam int c_EW = c_CNT_W + 1;

    localparam logic [c_EW-1:0]    c_H_ACT_E  = c_EW'(H_ACTIVE);
    localparam logic [c_EW-1:0]    c_HS_BEG_E = c_EW'(H_ACTIVE + H_FP);
    localparam logic [c_EW-1:0]    c_HS_END_E = c_EW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [c_EW-1:0]    c_V_ACT_E  = c_EW'(V_ACTIVE);
    localparam logic [c_EW-1:0]    c_VS_BEG_E = c_EW'(V_ACTIVE + V_FP);
    localparam logic [c_EW-1:0]    c_VS_END_E = c_EW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [c_CNT_W-1:0] c_H_LAST   = c_CNT_W'(c_HTOT - 1);
    localparam logic               c_SYNC_ACT = (SYNC_POL != 0);

    // Counters are 11 bits; a line must also be at least two pixels so that
    // the last pixel of a line is never also a wrap into the next one.
    if (c_HTOT > c_CNT_LIMIT || c_VTOT > c_CNT_LIMIT || c_HTOT < 2 || c_VTOT < 1)
    begin : g_bad_totals
        $error("vga_timing_gen: H_TOTAL=%0d / V_TOTAL=%0d outside 2..2048 / 1..2048",
               c_HTOT, c_VTOT);
    end

    logic [c_CNT_W-1:0] w_h_next;
    logic [c_CNT_W-1:0] w_v_next;
    logic               w_h_tc;
    logic               w_v_tc;

    wrap_counter #(
        .WIDTH (c_CNT_W),
        .MAX   (c_HTOT - 1)
    ) u_hcnt (
        .clk     (pclk),
        .rst_n   (rst_n),
        .i_en    (1'b1),
        .o_count (hcount),
        .o_next  (w_h_next),
        .o_tc    (w_h_tc)
    );

    // Lines advance only on the edge where the column wraps.
    wrap_counter #(
        .WIDTH (c_CNT_W),
        .MAX   (c_VTOT - 1)
    ) u_vcnt (
        .clk     (pclk),
        .rst_n   (rst_n),
        .i_en    (w_h_tc),
        .o_count (vcount),
        .o_next  (w_v_next),
        .o_tc    (w_v_tc)
    );

    logic [c_EW-1:0] w_h_ext;
    logic [c_EW-1:0] w_v_ext;
    logic            w_hblnk_d;
    logic            w_vblnk_d;
    logic            w_hsync_on;
    logic            w_vsync_on;
    logic            w_frame_end_d;

    always_comb begin
        w_h_ext    = {1'b0, w_h_next};
        w_v_ext    = {1'b0, w_v_next};
        w_hblnk_d  = (w_h_ext >= c_H_ACT_E);
        w_vblnk_d  = (w_v_ext >= c_V_ACT_E);
        w_hsync_on = (w_h_ext >= c_HS_BEG_E) && (w_h_ext < c_HS_END_E);
        w_vsync_on = (w_v_ext >= c_VS_BEG_E) && (w_v_ext < c_VS_END_E);
        // If the next column is the last one, the line is not wrapping on
        // this edge, so the next line equals the current line and the
        // current-line terminal count tells us it is the last line.
        w_frame_end_d = (w_h_next == c_H_LAST) && w_v_tc;
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            hsync     <= ~c_SYNC_ACT;
            vsync     <= ~c_SYNC_ACT;
            hblnk     <= 1'b0;
            vblnk     <= 1'b0;
            de        <= 1'b0;
            frame_end <= 1'b0;
        end else begin
            hsync     <= w_hsync_on ? c_SYNC_ACT : ~c_SYNC_ACT;
            vsync     <= w_vsync_on ? c_SYNC_ACT : ~c_SYNC_ACT;
            hblnk     <= w_hblnk_d;
            vblnk     <= w_vblnk_d;
            de        <= ~w_hblnk_d & ~w_vblnk_d;
            frame_end <= w_frame_end_d;
        end
    end

endmodule
`default_nettype wire
